// File: rtl/flow_light_sequencer.sv
// flow_light_sequencer
// Drives the 16-LED flow-light display from one push button.
// The raw button passes through a 2-flop synchroniser and a debouncer. Each
// debounced press moves an IDLE/RUN/PAUSE state machine on by one state. In
// RUN a prescaler moves a lit window one position every STEP_DIV clocks.
// The window width and the direction are captured when the sequence starts.
// Optional feature macro: FLOW_BOUNCE_EN. When it is defined, the window
// ping-pongs between the two ends of the strip and does not wrap around.
module flow_light_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STEP_DIV        = 8,
    parameter int LED_W           = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_button,
    input  logic             io_stop,
    input  logic [2:0]       io_ledCount,
    input  logic             io_dirSel,
    output logic [LED_W-1:0] io_led,
    output logic             io_running,
    output logic             io_step,
    output logic [2:0]       io_width
);

    localparam int PW = $clog2(LED_W);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW = $clog2(STEP_DIV);

    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] PRE_LAST = SW'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // Button path.
    logic          sync1_q, sync2_q;
    logic [CW-1:0] deb_cnt_q, deb_cnt_d;
    logic          deb_level_q, deb_level_d;
    logic          press_q, press_d;

    // Sequencer state.
    state_t        state_q, state_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [SW-1:0] pre_q, pre_d;
    logic [2:0]    width_q, width_d;
    logic          dir_q, dir_d;
    logic [LED_W-1:0] led_q, led_d;
    logic          step_now;

    // Position and direction that the window takes when the current step is applied.
    logic [PW-1:0] adv_pos;
    logic          adv_dir;

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= io_button;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count consecutive synced samples that disagree with the level.
    // The flip happens when the count reaches DEBOUNCE_CYCLES. Only a rising flip raises a press.
    always_comb begin
        deb_cnt_d   = '0;
        deb_level_d = deb_level_q;
        press_d     = 1'b0;
        if (sync2_q != deb_level_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_level_d = sync2_q;
                press_d     = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + CW'(1);
            end
        end
    end

    // Debounce registers; press_q is a one-cycle pulse the FSM consumes next edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            deb_cnt_q   <= '0;
            deb_level_q <= 1'b0;
            press_q     <= 1'b0;
        end else begin
            deb_cnt_q   <= deb_cnt_d;
            deb_level_q <= deb_level_d;
            press_q     <= press_d;
        end
    end

`ifdef FLOW_BOUNCE_EN
    // Highest legal start position of the window when it may not wrap.
    logic [PW:0] top_pos;
    assign top_pos = (PW+1)'(LED_W) - (PW+1)'(width_q);

    // Ping-pong step: a step that would leave the range reverses the direction
    // and moves one position back the other way.
    always_comb begin
        adv_pos = pos_q;
        adv_dir = dir_q;
        if (!dir_q) begin
            if ({1'b0, pos_q} >= top_pos) begin
                adv_dir = 1'b1;
                adv_pos = pos_q - PW'(1);
            end else begin
                adv_pos = pos_q + PW'(1);
            end
        end else begin
            if (pos_q == '0) begin
                adv_dir = 1'b0;
                adv_pos = pos_q + PW'(1);
            end else begin
                adv_pos = pos_q - PW'(1);
            end
        end
    end
`else
    // Wrapping step: the position counter simply rolls over modulo LED_W.
    always_comb begin
        adv_dir = dir_q;
        adv_pos = dir_q ? (pos_q - PW'(1)) : (pos_q + PW'(1));
    end
`endif

    // Next-state logic. A stop overrides everything. In RUN the step at
    // terminal count is applied before a coincident press moves us to PAUSE.
    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        pre_d    = pre_q;
        width_d  = width_q;
        dir_d    = dir_q;
        step_now = 1'b0;
        if (io_stop) begin
            state_d = ST_IDLE;
            pos_d   = '0;
            pre_d   = '0;
            width_d = 3'd0;
            dir_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (press_q) begin
                        width_d = (io_ledCount == 3'd0) ? 3'd1 : io_ledCount;
                        dir_d   = io_dirSel;
                        pos_d   = '0;
                        pre_d   = '0;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (pre_q == PRE_LAST) begin
                        step_now = 1'b1;
                        pre_d    = '0;
                        pos_d    = adv_pos;
                        dir_d    = adv_dir;
                    end else if (!press_q) begin
                        pre_d = pre_q + SW'(1);
                    end
                    if (press_q) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (press_q) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // LED i is lit when its distance above the window base, modulo LED_W, is below the width.
    // The pattern is computed from the next state, so the LEDs and the position always agree.
    generate
        for (genvar gi = 0; gi < LED_W; gi++) begin : g_led
            logic [PW-1:0] offset;
            assign offset    = PW'(gi) - pos_d;
            assign led_d[gi] = (state_d != ST_IDLE) && (32'(offset) < 32'(width_d));
        end
    endgenerate

    // Sequencer state and registered LED pattern.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pos_q   <= '0;
            pre_q   <= '0;
            width_q <= 3'd0;
            dir_q   <= 1'b0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            pre_q   <= pre_d;
            width_q <= width_d;
            dir_q   <= dir_d;
            led_q   <= led_d;
        end
    end

    assign io_led     = led_q;
    assign io_running = (state_q == ST_RUN);
    assign io_step    = step_now;
    assign io_width   = width_q;

endmodule

// File: tb/tb_flow_light_sequencer.sv
// Testbench for flow_light_sequencer.
// The bench runs a step-level model of the sequencer in parallel with the DUT.
// Each model edge updates the button level, the state, the prescaler and the
// window position. The LED pattern is computed from the window rule. Every
// falling edge compares the DUT against the model. Literal expectations at
// key points pin the model.
`timescale 1ns/1ps
module tb_flow_light_sequencer;
    localparam int DEB  = 4;
    localparam int SDIV = 8;
    localparam int LW   = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          io_button = 1'b0;
    logic          io_stop = 1'b0;
    logic [2:0]    io_ledCount = 3'd0;
    logic          io_dirSel = 1'b0;
    logic [LW-1:0] io_led;
    logic          io_running;
    logic          io_step;
    logic [2:0]    io_width;

    int total = 0;
    int bad   = 0;

    // Model state: m_st 0=idle 1=run 2=pause.
    int m_st, m_pos, m_pre, m_w, m_d;
    int m_s1, m_s2, m_lvl, m_cnt, m_press;

    always #5 clock = ~clock;

    flow_light_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .STEP_DIV(SDIV),
        .LED_W(LW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .io_button(io_button),
        .io_stop(io_stop),
        .io_ledCount(io_ledCount),
        .io_dirSel(io_dirSel),
        .io_led(io_led),
        .io_running(io_running),
        .io_step(io_step),
        .io_width(io_width)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [LW-1:0] pattern(input int pos, input int w);
        logic [LW-1:0] p;
        p = '0;
        for (int i = 0; i < LW; i++) begin
            if ((((i - pos) % LW) + LW) % LW < w) p[i] = 1'b1;
        end
        return p;
    endfunction

    task automatic model_reset();
        m_st = 0; m_pos = 0; m_pre = 0; m_w = 0; m_d = 0;
        m_s1 = 0; m_s2 = 0; m_lvl = 0; m_cnt = 0; m_press = 0;
    endtask

    task automatic model_advance();
`ifdef FLOW_BOUNCE_EN
        if (m_d == 0) begin
            if (m_pos + 1 > LW - m_w) begin m_d = 1; m_pos = m_pos - 1; end
            else m_pos = m_pos + 1;
        end else begin
            if (m_pos == 0) begin m_d = 0; m_pos = m_pos + 1; end
            else m_pos = m_pos - 1;
        end
`else
        m_pos = (m_d == 0) ? (m_pos + 1) % LW : (m_pos + LW - 1) % LW;
`endif
    endtask

    task automatic model_edge();
        int new_press;
        if (io_stop) begin
            m_st = 0; m_pos = 0; m_pre = 0; m_w = 0; m_d = 0;
        end else if (m_st == 0) begin
            if (m_press != 0) begin
                m_w   = (io_ledCount == 3'd0) ? 1 : int'(io_ledCount);
                m_d   = int'(io_dirSel);
                m_pos = 0;
                m_pre = 0;
                m_st  = 1;
            end
        end else if (m_st == 1) begin
            if (m_pre == SDIV - 1) begin
                m_pre = 0;
                model_advance();
            end else if (m_press == 0) begin
                m_pre = m_pre + 1;
            end
            if (m_press != 0) m_st = 2;
        end else begin
            if (m_press != 0) m_st = 1;
        end
        new_press = 0;
        if (m_s2 != m_lvl) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == DEB) begin
                m_lvl = m_s2;
                m_cnt = 0;
                new_press = m_lvl;
            end
        end else begin
            m_cnt = 0;
        end
        m_s2 = m_s1;
        m_s1 = int'(io_button);
        m_press = new_press;
    endtask

    // Model update on each clock edge and on asynchronous reset.
    initial begin
        model_reset();
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) model_reset();
            else model_edge();
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clock);
            check("led", io_led, (m_st == 0) ? '0 : pattern(m_pos, m_w));
            check("running", io_running, (m_st == 1) ? 1 : 0);
            check("width", io_width, m_w);
            check("step", io_step, (m_st == 1 && m_pre == SDIV - 1 && !io_stop) ? 1 : 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic wait_running(input string name, input logic exp);
        int n;
        n = 0;
        while (io_running !== exp && n < 60) begin
            tick(1);
            n++;
        end
        check(name, io_running, exp);
    endtask

    task automatic wait_step(input string name);
        int n;
        n = 0;
        while (io_step !== 1'b1 && n < 2 * SDIV + 4) begin
            tick(1);
            n++;
        end
        check(name, io_step, 1);
        tick(1);
    endtask

    initial begin
        logic [LW-1:0] frozen;
        int            stray;
        int            n;

        // Reset state.
        tick(3);
        check("rst_led", io_led, 16'h0000);
        check("rst_running", io_running, 0);
        check("rst_width", io_width, 0);
        reset = 1'b1;
        tick(2);

        // Test 1: a short 3-cycle pulse is rejected by the debouncer.
        io_button = 1'b1;
        tick(3);
        io_button = 1'b0;
        tick(12);
        check("short_led", io_led, 16'h0000);
        check("short_running", io_running, 0);
        $display("short pulse: led=%h running=%0d", io_led, io_running);

        // Test 2: width 3, toward MSB, full wrap.
        io_ledCount = 3'd3;
        io_dirSel   = 1'b0;
        io_button   = 1'b1;
        wait_running("start_run", 1'b1);
        io_button = 1'b0;
        check("start_led", io_led, 16'h0007);
        check("start_width", io_width, 3);
        wait_step("step1");
        check("step1_led", io_led, 16'h000E);
        wait_step("step2");
        check("step2_led", io_led, 16'h001C);
        for (int k = 3; k <= 14; k++) wait_step("stepk");
        check("wrap14_led", io_led, 16'hC001);
        wait_step("step15");
        wait_step("step16");
        check("wrap16_led", io_led, 16'h0007);
        $display("wrap run: led=%h", io_led);

        // Test 4: pause 3 cycles after a step, then resume.
        wait_step("pre_pause_step");
        tick(4);
        io_button = 1'b1;
        wait_running("pause_enter", 1'b0);
        io_button = 1'b0;
        frozen = io_led;
        stray  = 0;
        for (int k = 0; k < 40; k++) begin
            tick(1);
            if (io_step !== 1'b0 || io_led !== frozen) stray++;
        end
        check("pause_frozen", stray, 0);
        io_button = 1'b1;
        wait_running("resume", 1'b1);
        io_button = 1'b0;
        n = 0;
        while (io_step !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        check("resume_latency", n, 5);
        $display("pause/resume: frozen=%h latency=%0d", frozen, n);

        // Test 5: stop coincident with a press while paused.
        tick(10);
        io_button = 1'b1;
        wait_running("pause2_enter", 1'b0);
        io_button = 1'b0;
        tick(10);
        io_button = 1'b1;
        tick(6);
        io_stop = 1'b1;
        tick(1);
        io_stop = 1'b0;
        check("stop_led", io_led, 16'h0000);
        check("stop_width", io_width, 0);
        check("stop_running", io_running, 0);
        io_button = 1'b0;
        tick(10);
        check("stop_stays_idle", io_running, 0);
        io_button = 1'b1;
        wait_running("restart", 1'b1);
        io_button = 1'b0;
        check("restart_led", io_led, 16'h0007);
        $display("stop+press: restart led=%h", io_led);

        // Test 3: width 0 means 1, toward LSB; later width changes ignored.
        tick(10);
        io_stop = 1'b1;
        tick(1);
        io_stop = 1'b0;
        io_ledCount = 3'd0;
        io_dirSel   = 1'b1;
        io_button   = 1'b1;
        wait_running("w1_run", 1'b1);
        io_button   = 1'b0;
        check("w1_width", io_width, 1);
        check("w1_led", io_led, 16'h0001);
        io_ledCount = 3'd5;
        io_dirSel   = 1'b0;
        wait_step("w1_step");
        check("w1_step_led", io_led, 16'h8000);
        check("w1_width_held", io_width, 1);
        $display("width1 down: led=%h width=%0d", io_led, io_width);

        // Test 6: asynchronous reset in the middle of a run.
        tick(10);
        @(posedge clock);
        #3 reset = 1'b0;
        #1;
        check("async_led", io_led, 16'h0000);
        check("async_running", io_running, 0);
        check("async_width", io_width, 0);
        tick(2);
        reset = 1'b1;
        io_ledCount = 3'd3;
        io_dirSel   = 1'b0;
        tick(2);
        io_button = 1'b1;
        wait_running("post_reset_run", 1'b1);
        io_button = 1'b0;
        check("post_reset_led", io_led, 16'h0007);
        $display("async reset: restart led=%h", io_led);

`ifdef FLOW_BOUNCE_EN
        // Test 7: ping-pong at the top end.
        n = 0;
        while (io_led !== 16'hE000 && n < 20) begin
            wait_step("bounce_up");
            n++;
        end
        check("bounce_top", io_led, 16'hE000);
        wait_step("bounce_turn");
        check("bounce_back", io_led, 16'h7000);
        wait_step("bounce_down");
        check("bounce_down_led", io_led, 16'h3800);
        $display("bounce: led=%h", io_led);
`endif

        tick(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/flow_light_sequencer.md
Name: flow_light_sequencer

Overview:
Controller that sequences the 16-LED flow-light display from a single push button. It debounces the button and runs an IDLE/RUN/PAUSE state machine. A prescaler schedules the step events, and the block latches the lit-window width and direction at start. Its output drives the board LEDs directly and replaces the free-running shifter at the top level.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronised samples that must differ from the debounced level before it flips (>=1)
STEP_DIV, 8, clock cycles per window step (>=2)
LED_W, 16, number of LEDs (power of two; position counter is log2(LED_W) bits)

Ports:
clock  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-low reset
io_button  in  1  raw push button, active-high, asynchronous to clock
io_stop  in  1  synchronous level; forces IDLE
io_ledCount  in  3  requested lit-window width; sampled only at start
io_dirSel  in  1  0 = window moves toward MSB, 1 = toward LSB; sampled only at start
io_led  out  LED_W  LED pattern
io_running  out  1  high in RUN
io_step  out  1  one-cycle pulse on each window advance
io_width  out  3  latched window width in use

Behaviour:
- Reset (reset=0): applies asynchronously.
  - All outputs 0; state IDLE; pos=0; prescaler=0.
  - Debounced level 0; synchroniser flops 0.
- Button path:
  - 2-flop synchroniser, then a debounce counter.
  - The counter increments while the synced value differs from the debounced level and clears otherwise.
  - When the count reaches DEBOUNCE_CYCLES, the level flips and the counter clears.
  - press = one-cycle pulse on a debounced 0->1 transition; release generates nothing.
  - Latency: raw high sampled at edge t -> press asserted after edge t+1+DEBOUNCE_CYCLES -> FSM updates at the following edge.
- FSM:
  - IDLE: io_led=0, io_step=0.
    - On press: width = (io_ledCount==0) ? 1 : io_ledCount. Latch dir=io_dirSel; pos=0; prescaler=0; go to RUN.
  - RUN: prescaler counts 0..STEP_DIV-1.
    - At terminal count, io_step=1 for that cycle and pos advances at the same edge.
    - dir=0: pos+1 mod LED_W. dir=1: pos-1 mod LED_W (0 -> LED_W-1).
    - On press: go to PAUSE; prescaler and pos hold.
  - PAUSE: io_step=0; io_led frozen.
    - On press: back to RUN; prescaler resumes from its held value.
  - io_stop=1 in any state: IDLE at the next edge; pos and prescaler cleared.
- Pattern (registered): io_led[i]=1 iff ((i - pos) mod LED_W) < width. The window wraps from MSB to LSB.
- io_running=1 exactly in RUN; io_width shows the latched width (0 in IDLE).
- Simultaneous events:
  - io_stop together with press: stop wins.
  - In RUN, terminal count together with press: the step is taken (pulse and advance), then PAUSE.
  - io_ledCount and io_dirSel changes outside the IDLE->RUN transition are ignored.
- Reset asserted mid-RUN: immediate return to the reset values. A held button after reset release needs a full debounce before it is recognised (level starts at 0).

Optional Feature:
FLOW_BOUNCE_EN
- Defined:
  - pos ranges 0..LED_W-width with no wrap.
  - When a step would leave that range, dir toggles and the step moves one position the other way.
  - Ping-pong: width 3 goes pos 13 -> 12 after reaching the top.
- Undefined: wrap-around behaviour as in Behaviour.

Test Plan:
(Defaults; 1 step = 8 clocks.)
1. Hold io_button high 3 cycles, then low -> no press; io_led stays 0x0000, io_running stays 0.
2. io_ledCount=3, io_dirSel=0, clean press -> io_led=0x0007 and io_running=1. io_step pulses every 8 cycles. io_led goes 0x000E, 0x001C, ... After 14 steps io_led=0xC001 (wrap); after 16 steps 0x0007.
3. io_ledCount=0, io_dirSel=1, press -> io_width=1, io_led=0x0001. After 1 step 0x8000. io_ledCount changed to 5 mid-run leaves io_width=1.
4. In RUN, press 3 cycles after a step -> PAUSE: io_led frozen and no io_step for 40 cycles. Press again -> RUN, first io_step exactly 5 cycles after re-entry.
5. io_stop=1 on the same cycle as a press in PAUSE -> IDLE, io_led=0x0000, io_width=0. A later press restarts at pos 0.
6. reset=0 asynchronously mid-RUN (between clock edges) -> io_led=0 and io_running=0 before the next edge. Release, then press -> normal start.
7. With FLOW_BOUNCE_EN, width 3 -> io_led reaches 0xE000, then 0x7000, then moves back down toward 0x0007.
